seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg_scan_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking gap.
// Optional build macro SEG_LEADZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned GAP_CYC  = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam logic [15:0] LP_CNT_LAST = 16'(SCAN_DIV - 1);
   localparam logic [15:0] LP_GAP_LAST = 16'(GAP_CYC - 1);

   localparam logic [0:0] ST_GAP = 1'b0;
   localparam logic [0:0] ST_ON  = 1'b1;

   logic [15:0] r_shadow;
   logic [3:0]  r_shadow_dp;
   logic [1:0]  r_idx;
   logic [15:0] r_cnt;
   logic [0:0]  r_state;
   logic [3:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_dp;
   logic        r_frame_done;

   logic        w_cnt_wrap;
   logic [3:0]  w_nibble;
   logic [6:0]  w_seg_dec;
   logic [3:0]  w_an_on;
   logic        w_blank;

   assign w_cnt_wrap = (r_cnt == LP_CNT_LAST);
   assign w_nibble   = r_shadow[{r_idx, 2'b00} +: 4];
   assign w_an_on    = ~(4'b0001 << r_idx);

   always_comb begin
      w_seg_dec = 7'b1111111;
      case (w_nibble)
         4'd0:    w_seg_dec = 7'b1000000;
         4'd1:    w_seg_dec = 7'b1111001;
         4'd2:    w_seg_dec = 7'b0100100;
         4'd3:    w_seg_dec = 7'b0110000;
         4'd4:    w_seg_dec = 7'b0011001;
         4'd5:    w_seg_dec = 7'b0010010;
         4'd6:    w_seg_dec = 7'b0000010;
         4'd7:    w_seg_dec = 7'b1111000;
         4'd8:    w_seg_dec = 7'b0000000;
         4'd9:    w_seg_dec = 7'b0010000;
         default: w_seg_dec = 7'b1111111;
      endcase
   end

`ifdef SEG_LEADZERO_BLANK_EN
   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      w_blank = 1'b0;
      case (r_idx)
         2'd3:    w_blank = (r_shadow[15:12] == 4'd0);
         2'd2:    w_blank = (r_shadow[15:8]  == 8'd0);
         2'd1:    w_blank = (r_shadow[15:4]  == 12'd0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   // Outputs are registered from the current counter phase, so the first cycle
   // of every slot always shows the GAP values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow     <= '0;
         r_shadow_dp  <= '0;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_state      <= ST_GAP;
         r_an         <= '1;
         r_seg        <= '1;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         if (load) begin
            r_shadow    <= digits_in;
            r_shadow_dp <= dp_in;
         end

         r_cnt <= w_cnt_wrap ? '0 : r_cnt + 16'd1;
         if (w_cnt_wrap) begin
            r_idx <= r_idx + 2'd1;
         end

         if (w_cnt_wrap) begin
            r_state <= ST_GAP;
         end else if (r_cnt == LP_GAP_LAST) begin
            r_state <= ST_ON;
         end

         if (r_state == ST_ON) begin
            r_an  <= w_an_on;
            r_seg <= w_blank ? 7'b1111111 : w_seg_dec;
            r_dp  <= ~r_shadow_dp[r_idx];
         end else begin
            r_an  <= '1;
            r_seg <= '1;
            r_dp  <= 1'b1;
         end

         r_frame_done <= w_cnt_wrap && (r_idx == 2'd3);
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver (SCAN_DIV=8, GAP_CYC=2).
// Expected outputs derive from the edge count since reset; honours SEG_LEADZERO_BLANK_EN.
module tb_seg_scan_driver;

   localparam int unsigned SCAN_DIV = 8;
   localparam int unsigned GAP_CYC  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seg_scan_driver #(
      .SCAN_DIV(SCAN_DIV),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned checks   = 0;
   int unsigned errors   = 0;
   int unsigned n_edges  = 0;
   int unsigned fd_seen  = 0;
   logic [15:0] m_shadow = '0;
   logic [3:0]  m_sdp    = '0;
   logic [6:0]  dec_tbl [16];

   // Prediction for the next edge: edge k after reset shows counter value (k-1).
   function automatic exp_t predict();
      exp_t        e;
      int unsigned pos;
      int unsigned dig;
      logic [15:0] upper;
      pos   = n_edges % SCAN_DIV;
      dig   = (n_edges / SCAN_DIV) % 4;
      e     = '{4'hF, 7'h7F, 1'b1, 1'b0};
      e.fd  = (pos == SCAN_DIV - 1) && (dig == 3);
      if (pos >= GAP_CYC) begin
         upper     = m_shadow >> (4 * dig);
         e.an      = 4'hF;
         e.an[dig] = 1'b0;
         e.seg     = dec_tbl[upper[3:0]];
`ifdef SEG_LEADZERO_BLANK_EN
         if (dig != 0 && upper == 16'd0) e.seg = 7'h7F;
`endif
         e.dp = ~m_sdp[dig];
      end
      return e;
   endfunction

   task automatic step(input logic r, input logic ld, input logic [15:0] d,
                       input logic [3:0] p, input string tag);
      exp_t e;
      exp_t x;
      @(negedge clk);
      rst       = r;
      load      = ld;
      digits_in = d;
      dp_in     = p;
      if (r) begin
         e        = '{4'hF, 7'h7F, 1'b1, 1'b0};
         n_edges  = 0;
         m_shadow = '0;
         m_sdp    = '0;
      end else begin
         e = predict();
         n_edges++;
         if (ld) begin
            m_shadow = d;
            m_sdp    = p;
         end
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      checks++;
      assert (an === x.an) else begin
         errors++;
         $error("FAIL %s an edge=%0d got %b exp %b", tag, n_edges, an, x.an);
      end
      checks++;
      assert (seg === x.seg) else begin
         errors++;
         $error("FAIL %s seg edge=%0d got %b exp %b", tag, n_edges, seg, x.seg);
      end
      checks++;
      assert (dp === x.dp) else begin
         errors++;
         $error("FAIL %s dp edge=%0d got %b exp %b", tag, n_edges, dp, x.dp);
      end
      checks++;
      assert (frame_done === x.fd) else begin
         errors++;
         $error("FAIL %s frame_done edge=%0d got %b exp %b", tag, n_edges, frame_done, x.fd);
      end
      checks++;
      assert ($countones(~an) <= 1) else begin
         errors++;
         $error("FAIL %s one_anode edge=%0d got %b exp at most one low", tag, n_edges, an);
      end
      if (frame_done === 1'b1) fd_seen++;
   endtask

   task automatic idle(input int unsigned cnt, input string tag);
      for (int unsigned i = 0; i < cnt; i++) step(1'b0, 1'b0, 16'h0000, 4'h0, tag);
   endtask

   // Advance (bounded) until the next edge lands on the given digit/position.
   task automatic run_until(input int unsigned dig, input int unsigned pos, input string tag);
      int unsigned k;
      k = 0;
      while (!((n_edges % SCAN_DIV) == pos && ((n_edges / SCAN_DIV) % 4) == dig) && k < 64) begin
         step(1'b0, 1'b0, 16'h0000, 4'h0, tag);
         k++;
      end
   endtask

   initial begin
      dec_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

      // Reset with load held high: shadow must stay zero.
      step(1'b1, 1'b1, 16'hFFFF, 4'hF, "reset");
      step(1'b1, 1'b1, 16'hFFFF, 4'hF, "reset");
      step(1'b1, 1'b1, 16'hFFFF, 4'hF, "reset");
      idle(10, "post_reset");

      // Basic scan and frame pulse cadence.
      step(1'b0, 1'b1, 16'h1234, 4'b0100, "load_1234");
      idle(8, "scan_1234");
      fd_seen = 0;
      idle(32, "scan_1234");
      checks++;
      assert (fd_seen == 1) else begin
         errors++;
         $error("FAIL frame_count got %0d exp 1", fd_seen);
      end

      // Invalid BCD nibbles blank with anode still active.
      step(1'b0, 1'b1, 16'hA0F9, 4'b0000, "load_A0F9");
      idle(34, "scan_A0F9");

      // Mid-frame loads: last one before digit2's ON phase wins.
      run_until(1, 4, "seek_d1_on");
      step(1'b0, 1'b1, 16'h0000, 4'b0000, "load_0000_d1on");
      run_until(2, 0, "seek_d2_gap");
      step(1'b0, 1'b1, 16'h5678, 4'b1010, "load_5678_d2gap");
      step(1'b0, 1'b1, 16'h5678, 4'b1010, "load_5678_b2b");
      idle(34, "scan_5678");

      // Reset during digit3's ON phase.
      run_until(3, 4, "seek_d3_on");
      step(1'b1, 1'b0, 16'h0000, 4'h0, "reset_mid");
      idle(20, "after_reset_mid");

      // Leading-zero behaviour depends on the build macro.
      step(1'b0, 1'b1, 16'h0050, 4'b0001, "load_0050");
      idle(34, "scan_0050");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
